// File: rtl/qr_pkg.sv
// Shared QR version-1 geometry: sizes, FSM states, module classification, grid addressing.
// Pure declarations and combinational helpers; no latency.
// No flow control here; the importing stages handle backpressure.
package qr_pkg;

    localparam int QR_V1_SIZE      = 21;
    localparam int QR_V1_CODEWORDS = 26;
    localparam int QR_TIMING_POS   = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_EMIT = 2'd2
    } ext_state_t;

    // UP walks towards row 0, DOWN towards row 20.
    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } walk_dir_t;

    // Finder patterns with separators and format areas, the dark module, and both timing lines.
    function automatic logic is_function_module(input logic [4:0] row, input logic [4:0] col);
        logic top, bottom, left, right;
        top    = (row <= 5'd8);
        bottom = (row >= 5'd13);
        left   = (col <= 5'd8);
        right  = (col >= 5'd13);
        return (top && left) || (top && right) || (bottom && left) ||
               (row == 5'(QR_TIMING_POS)) || (col == 5'(QR_TIMING_POS));
    endfunction

    // Bit index of a module in the flattened grid; row 0 sits in the high bits of each column word.
    function automatic logic [8:0] grid_addr(input logic [4:0] row, input logic [4:0] col);
        int a;
        a = (QR_V1_SIZE - 1 - int'(row)) + int'(col) * QR_V1_SIZE;
        return a[8:0];
    endfunction

endpackage

// File: rtl/qr_zigzag_walker.sv
// Generates the zig-zag module visit order of a version-1 QR grid, one module per advance.
// Position is registered; row/col/is_data/last describe the module visited in the current cycle.
// Advance is a stall control: with advance low the position holds; restart wins over advance.
module qr_zigzag_walker
    import qr_pkg::*;
(
    input  logic       clk_in,
    input  logic       rst_in,
    input  logic       advance_i,
    input  logic       restart_i,
    output logic [4:0] row_o,
    output logic [4:0] col_o,
    output logic       is_data_o,
    output logic       last_o
);

    logic [4:0] row_q, row_d;
    logic [4:0] col_q, col_d;
    logic       right_q, right_d;
    walk_dir_t  dir_q, dir_d;
    logic       at_edge;

    assign row_o     = row_q;
    assign col_o     = col_q;
    assign is_data_o = !is_function_module(row_q, col_q);
    assign last_o    = (col_q == 5'd0) && (row_q == 5'(QR_V1_SIZE - 1)) && !right_q;
    assign at_edge   = ((dir_q == DIR_UP) && (row_q == 5'd0)) ||
                       ((dir_q == DIR_DOWN) && (row_q == 5'(QR_V1_SIZE - 1)));

    // Next position: right then left of the pair, then step row; at the edge hop to the next pair.
    always_comb begin
        row_d   = row_q;
        col_d   = col_q;
        right_d = right_q;
        dir_d   = dir_q;
        if (restart_i) begin
            row_d   = 5'(QR_V1_SIZE - 1);
            col_d   = 5'(QR_V1_SIZE - 1);
            right_d = 1'b1;
            dir_d   = DIR_UP;
        end else if (advance_i && !last_o) begin
            if (right_q) begin
                col_d   = col_q - 5'd1;
                right_d = 1'b0;
            end else if (at_edge) begin
                // The pair to the left of column 7 skips the vertical timing column.
                col_d   = (col_q == 5'(QR_TIMING_POS + 1)) ? 5'(QR_TIMING_POS - 1) : col_q - 5'd1;
                right_d = 1'b1;
                dir_d   = (dir_q == DIR_UP) ? DIR_DOWN : DIR_UP;
            end else begin
                row_d   = (dir_q == DIR_UP) ? row_q - 5'd1 : row_q + 5'd1;
                col_d   = col_q + 5'd1;
                right_d = 1'b1;
            end
        end
    end

    // Position registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            row_q   <= 5'd0;
            col_q   <= 5'd0;
            right_q <= 1'b0;
            dir_q   <= DIR_UP;
        end else begin
            row_q   <= row_d;
            col_q   <= col_d;
            right_q <= right_d;
            dir_q   <= dir_d;
        end
    end

endmodule

// File: rtl/codeword_extract.sv
// Latches an unmasked v1 QR grid and streams its 26 data codewords, first-scanned module in bit 7.
// One module visited per cycle; first codeword valid 8 cycles after start is sampled.
// valid/ready: codeword held stable while ready is low; the walk pauses until each codeword is taken.
module codeword_extract
    import qr_pkg::*;
#(
    parameter int MOD_SIZE      = QR_V1_SIZE,
    parameter int NUM_CODEWORDS = QR_V1_CODEWORDS
) (
    input  logic                         clk_in,
    input  logic                         rst_in,
    input  logic                         start_extract,
    input  logic [MOD_SIZE*MOD_SIZE-1:0] qr_unmasked,
    input  logic                         codeword_ready,
    output logic [7:0]                   codeword_out,
    output logic                         codeword_valid,
    output logic [4:0]                   codeword_index,
    output logic                         extract_done
);

    ext_state_t                   state_q, state_d;
    logic [MOD_SIZE*MOD_SIZE-1:0] grid_q, grid_d;
    logic [7:0]                   shift_q, shift_d;
    logic [2:0]                   bitcnt_q, bitcnt_d;
    logic [7:0]                   cw_q, cw_d;
    logic                         valid_q, valid_d;
    logic [4:0]                   index_q, index_d;
    logic                         done_q, done_d;

    logic [4:0] walk_row, walk_col;
    logic       walk_is_data, walk_last;
    logic       walk_advance, walk_restart;
    logic       data_bit;

    qr_zigzag_walker u_walker (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .advance_i (walk_advance),
        .restart_i (walk_restart),
        .row_o     (walk_row),
        .col_o     (walk_col),
        .is_data_o (walk_is_data),
        .last_o    (walk_last)
    );

    assign codeword_out   = cw_q;
    assign codeword_valid = valid_q;
    assign codeword_index = index_q;
    assign extract_done   = done_q;

    // FSM next state: latch on start, pack data modules while scanning, hand off each byte.
    always_comb begin
        state_d      = state_q;
        grid_d       = grid_q;
        shift_d      = shift_q;
        bitcnt_d     = bitcnt_q;
        cw_d         = cw_q;
        valid_d      = valid_q;
        index_d      = index_q;
        done_d       = 1'b0;
        walk_advance = 1'b0;
        walk_restart = 1'b0;
        // Dark modules are stored as 0 and read as data 1.
        data_bit     = ~grid_q[grid_addr(walk_row, walk_col)];
        case (state_q)
            ST_IDLE: begin
                if (start_extract) begin
                    grid_d       = qr_unmasked;
                    shift_d      = 8'd0;
                    bitcnt_d     = 3'd0;
                    index_d      = 5'd0;
                    walk_restart = 1'b1;
                    state_d      = ST_SCAN;
                end
            end
            ST_SCAN: begin
                walk_advance = 1'b1;
                if (walk_is_data) begin
                    shift_d  = {shift_q[6:0], data_bit};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) begin
                        cw_d    = {shift_q[6:0], data_bit};
                        valid_d = 1'b1;
                        state_d = ST_EMIT;
                    end
                end else if (walk_last) begin
                    // Walk exhausted without completing a byte; abandon rather than hang.
                    state_d = ST_IDLE;
                end
            end
            ST_EMIT: begin
                if (codeword_ready) begin
                    valid_d = 1'b0;
                    if (index_q == 5'(NUM_CODEWORDS - 1)) begin
                        index_d = 5'd0;
                        done_d  = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        index_d = index_q + 5'd1;
                        state_d = ST_SCAN;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers; reset aborts any stream in flight.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            grid_q   <= '0;
            shift_q  <= 8'd0;
            bitcnt_q <= 3'd0;
            cw_q     <= 8'd0;
            valid_q  <= 1'b0;
            index_q  <= 5'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            grid_q   <= grid_d;
            shift_q  <= shift_d;
            bitcnt_q <= bitcnt_d;
            cw_q     <= cw_d;
            valid_q  <= valid_d;
            index_q  <= index_d;
            done_q   <= done_d;
        end
    end

endmodule
